// File: rtl/fifo_uart_tx.sv
// UART-style serializer that pops words from a sync_fifo (registered read port) and sends
// start, WIDTH data bits LSB first, optional even parity (define PARITY_EN), stop.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StStart,
    StData,
`ifdef PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;
`ifdef PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    fifo_rd = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) state_d = StRead;
      end
      StRead: begin
        fifo_rd = 1'b1;
        state_d = StLoad;
      end
      // fifo_data is valid here, one cycle after the read strobe
      StLoad: begin
        shift_d = fifo_data;
`ifdef PARITY_EN
        parity_d = ^fifo_data;
`endif
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b0;
        state_d = StStart;
      end
      StStart: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          if (idx_q == IdxLast) begin
`ifdef PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IdxW'(1);
            tx_d    = shift_d[0];
          end
        end
      end
`ifdef PARITY_EN
      StParity: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        done  = bit_end;
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and each
// frame is checked against the bit sequence expected for the popped word.
module tb_fifo_uart_tx;

  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 4;
`ifdef PARITY_EN
  localparam int unsigned NB  = W + 3;
`else
  localparam int unsigned NB  = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_rd;
  logic         tx;
  logic         busy;
  logic         done;

  fifo_uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model with a registered read port, plus the scoreboard of written words
  logic [W-1:0] mem [64];
  int           wptr = 0;
  int           rptr = 0;
  int           rd_count = 0;
  int           rd_empty_err = 0;
  logic [W-1:0] exp_q [$];

  assign fifo_empty = (wptr == rptr);

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      rd_count <= rd_count + 1;
      if (wptr == rptr) rd_empty_err <= rd_empty_err + 1;
      else begin
        fifo_data <= mem[rptr % 64];
        rptr      <= rptr + 1;
      end
    end
  end

  task automatic push(input logic [W-1:0] w);
    mem[wptr % 64] = w;
    wptr++;
    exp_q.push_back(w);
  endtask

  task automatic check_frame(input bit drop_en, output int gap);
    logic [W-1:0]   w;
    logic [W-1:0]   dec;
    logic [NB-1:0]  bits;
    logic [CPB-1:0] pat;
    logic [CPB-1:0] want;
    int idle_bad, done_pos, done_cnt, rd_extra, busy_bad;
    gap = 0;
    idle_bad = 0;
    do begin
      @(negedge clk);
      gap++;
      if (tx !== 1'b1) idle_bad++;
    end while (fifo_rd !== 1'b1 && gap < 200);
    check_eq("idle_tx_high", idle_bad, 0);
    if (fifo_rd !== 1'b1) begin
      check_eq("rd_timeout", fifo_rd, 1);
      return;
    end
    check_eq("rd_with_data", exp_q.size() > 0, 1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = w[i];
`ifdef PARITY_EN
    bits[W+1] = ^w;
`endif
    bits[NB-1] = 1'b1;
    check_eq("read_busy", busy, 1);
    @(negedge clk);
    check_eq("load_rd", fifo_rd, 0);
    check_eq("load_tx", tx, 1);
    done_pos = 0; done_cnt = 0; rd_extra = 0; busy_bad = 0; dec = '0;
    for (int b = 0; b < NB; b++) begin
      pat = '0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (drop_en && b == 0 && c == 0) enable = 1'b0;
        pat[c] = tx;
        if (done === 1'b1) begin
          done_cnt++;
          done_pos = b * CPB + c + 1;
        end
        if (fifo_rd !== 1'b0) rd_extra++;
        if (busy !== 1'b1) busy_bad++;
      end
      want = {CPB{bits[b]}};
      check_eq($sformatf("bit%0d_w%02h", b, w), pat, want);
      if (b >= 1 && b <= W) dec[b-1] = pat[CPB/2];
    end
    check_eq("word", dec, w);
    check_eq("done_pos", done_pos, NB * CPB);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("rd_in_frame", rd_extra, 0);
    check_eq("busy_frame", busy_bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int gap, r0, bad, n;
    logic [W-1:0] junk;
    reset  = 1'b0;
    enable = 1'b0;

    // reset held with random enable and a word waiting
    push(8'hA5);
    repeat (10) begin
      @(posedge clk); #1 enable = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("rst_tx", tx, 1);
      check_eq("rst_rd", fifo_rd, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
    end
    @(posedge clk); #1 enable = 1'b0; reset = 1'b1;

    // single frame 0xA5
    @(posedge clk); #1 enable = 1'b1;
    check_frame(1'b0, gap);

    // empty FIFO with enable high
    r0 = rd_count; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("empty_rd", rd_count - r0, 0);
    check_eq("empty_idle", bad, 0);

    // back-to-back frames
    push(8'h00); push(8'hFF); push(8'h07);
    check_frame(1'b0, gap);
    for (int i = 0; i < 2; i++) begin
      check_frame(1'b0, gap);
      check_eq("b2b_gap", gap, 2);
    end

    // enable dropped during START with words still queued
    push(8'h11); push(8'h22); push(8'h33);
    check_frame(1'b1, gap);
    r0 = rd_count; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check_eq("drop_rd", rd_count - r0, 0);
    check_eq("drop_busy", bad, 0);
    enable = 1'b1;
    check_frame(1'b0, gap);
    check_frame(1'b0, gap);
    check_eq("resume_gap", gap, 2);

    // asynchronous reset in the middle of DATA
    push(8'h00);
    junk = exp_q.pop_back();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fifo_rd !== 1'b1 && n < 100);
    check_eq("mid_rst_rd", fifo_rd, 1);
    repeat (1 + CPB + 3) @(negedge clk);
    check_eq("pre_rst_tx", tx, 0);
    #1 reset = 1'b0;
    #1;
    check_eq("mid_rst_tx", tx, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    enable = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 enable = 1'b1;

    // eight words in order
    for (int i = 1; i <= 8; i++) push(W'(i));
    for (int i = 0; i < 8; i++) begin
      check_frame(1'b0, gap);
      if (i > 0) check_eq("seq_gap", gap, 2);
    end

    // random words with random idle spacing between bursts
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push(W'($urandom));
      for (int i = 0; i < n; i++) begin
        check_frame(1'b0, gap);
        if (i > 0) check_eq("rand_gap", gap, 2);
      end
    end

    repeat (5) @(negedge clk);
    check_eq("end_empty", fifo_empty, 1);
    check_eq("rd_while_empty", rd_empty_err, 0);
    check_eq("rd_total", rd_count, wptr);
    check_eq("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the team's synchronous FIFO (sync_fifo).
- Pops one WIDTH-bit word whenever the FIFO is non-empty and transmission is enabled, then serializes it onto a UART-style line: start bit, data LSB first, stop bit.
- Sits between the FIFO and the external serial pin.
- Accounts for the FIFO's registered read port: data_out is valid one cycle after the rd pulse.

Parameters:
- WIDTH, 8, data bits per frame; must match the FIFO's WIDTH.
- CLKS_PER_BIT, 16, clk cycles per serial bit period; minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = new frames may be started; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO data_out; valid the cycle after fifo_rd was high.
- fifo_rd  output  1  one-cycle read strobe to the FIFO's rd input.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, fifo_rd=0, busy=0, done=0, all counters and the shift register cleared.
- Reset asserted mid-frame aborts the frame immediately, and tx returns to 1.
- States: IDLE, READ, LOAD, START, DATA, [PARITY], STOP.
  - IDLE: if enable=1 and fifo_empty=0 at a clock edge -> READ; otherwise stay, tx=1.
  - READ: fifo_rd=1 for exactly this one cycle -> LOAD. fifo_rd is a Moore output and is 0 in every other state.
  - LOAD: capture fifo_data into the shift register, clear the baud counter -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=shift[0]; after CLKS_PER_BIT cycles, shift right and increment the bit index. After WIDTH bits -> PARITY if enabled, else STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; done=1 in the last of those cycles -> IDLE.
- tx is registered and glitch-free; it changes only on the edge that enters a new bit period.
- Baud counter: clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index: clog2(WIDTH+1) bits.
- Timing:
  - Latency from the IDLE edge that sees enable & !fifo_empty to the falling edge of tx: 2 cycles (READ, LOAD).
  - Frame length: (WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled.
  - Back-to-back frames: exactly 3 extra idle-high cycles between the stop bit and the next start bit (IDLE, READ, LOAD).
- Boundary conditions:
  - enable dropping mid-frame: the current frame completes; no new frame starts.
  - fifo_empty rising during READ/LOAD is ignored; the popped word is still sent.
  - Exactly one fifo_rd pulse per frame, never while fifo_empty=1 was sampled in IDLE.
  - Never more than one outstanding read.

Optional Feature:
- Macro PARITY_EN.
- Defined: a PARITY state is inserted after DATA. tx = XOR of the WIDTH data bits (even parity) for CLKS_PER_BIT cycles; frame length grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; DATA -> STOP directly.

Test Plan:
- Reset: hold reset=0 with random inputs -> tx=1, fifo_rd=0, busy=0, done=0. Assert reset=0 mid-DATA -> tx=1 and busy=0 immediately (asynchronously).
- Single frame (CLKS_PER_BIT=4, WIDTH=8, FIFO holds 0xA5, enable=1):
  - Exactly one fifo_rd pulse.
  - tx falls 2 cycles after the IDLE edge.
  - tx per 4-cycle period: 0 | 1,0,1,0,0,1,0,1 | 1.
  - done pulses in cycle 40 of the frame.
- Back-to-back (FIFO holds 0x00, 0xFF):
  - Two frames, two fifo_rd pulses.
  - Exactly 3 tx-high cycles between the end of stop bit 1 and start bit 2.
  - Data bits all 0, then all 1.
- Empty/enable gating:
  - fifo_empty=1 with enable=1 for 50 cycles -> no fifo_rd, tx=1, busy=0.
  - enable dropped during START of frame 1 with words still queued -> frame 1 completes; no further fifo_rd.
- PARITY_EN defined:
  - 0xA5 -> parity period tx=0.
  - 0x07 -> parity period tx=1.
  - Frame length 44 cycles at CLKS_PER_BIT=4.
- Integration with sync_fifo:
  - Write 8 words 0x01..0x08 -> serialized in order.
  - FIFO ends empty; fifo_rd never asserted while empty.
